// File: rtl/inst_rom_loader_pkg.sv
// Shared types and helpers for the instruction ROM boot loader.
// Holds the loader state encodings and the big-endian word packer.
package inst_rom_loader_pkg;

    localparam int          InstW    = 32;
    localparam logic [31:0] ZeroWord = 32'h0;

    typedef enum logic [1:0] {
        LdLoad = 2'd0,
        LdRun  = 2'd1,
        LdErr  = 2'd2
    } ld_state_e;

    // part holds earlier bytes of the word, most recent in the low lane;
    // lanes not yet filled come out as 0x00.
    function automatic logic [InstW-1:0] pack_word(input logic [23:0] part,
                                                   input logic [1:0]  bcnt,
                                                   input logic [7:0]  b);
        logic [InstW-1:0] w;
        case (bcnt)
            2'd0:    w = {b, 24'h0};
            2'd1:    w = {part[7:0], b, 16'h0};
            2'd2:    w = {part[15:0], b, 8'h0};
            default: w = {part[23:0], b};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_rom_loader_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one
// asynchronous read port. Contents survive reset.
module inst_rom_array
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [InstW-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [InstW-1:0]  rdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [InstW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Byte-serial boot loader in front of the core's instruction port: packs
// bytes big-endian into words, holds the core in reset until the image is in.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    input  logic              rom_ce,
    input  logic [31:0]       rom_addr,
    output logic [InstW-1:0]  rom_data,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_words
);

    localparam int              DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);

    ld_state_e       state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [ADDR_W:0] wcnt_q, wcnt_d;
    logic [23:0]     part_q, part_d;
    logic            armed_q;

    logic             we;
    logic [InstW-1:0] wdata;
    logic [InstW-1:0] rdata;
    logic             acc;

    // Only the word-index bits of the fetch address matter.
    logic unused_addr;
    assign unused_addr = ^{rom_addr[31:ADDR_W+2], rom_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LdLoad;
            bcnt_q  <= 2'd0;
            wcnt_q  <= '0;
            part_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            part_q  <= part_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        wcnt_d   = wcnt_q;
        part_d   = part_q;
        we       = 1'b0;
        wdata    = pack_word(part_q, bcnt_q, ld_byte);
        // ld_ready waits one edge after reset release before opening.
        ld_ready = (state_q == LdLoad) && armed_q;
        acc      = ld_valid && ld_ready && !reload;

        if (reload) begin
            state_d = LdLoad;
            bcnt_d  = 2'd0;
            wcnt_d  = '0;
        end else if (state_q == LdLoad && acc) begin
            if (wcnt_q == FULL) begin
                state_d = LdErr;
            end else if (ld_last || bcnt_q == 2'd3) begin
                we     = 1'b1;
                wcnt_d = wcnt_q + (ADDR_W+1)'(1);
                bcnt_d = 2'd0;
                if (ld_last) state_d = LdRun;
            end else begin
                bcnt_d = bcnt_q + 2'd1;
                part_d = {part_q[15:0], ld_byte};
            end
        end
    end

    inst_rom_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (wcnt_q[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (rom_addr[ADDR_W+1:2]),
        .rdata (rdata)
    );

    assign cpu_rst    = (state_q != LdRun);
    assign load_done  = (state_q == LdRun);
    assign load_err   = (state_q == LdErr);
    assign load_words = wcnt_q;
    assign rom_data   = (rom_ce && state_q == LdRun) ? rdata : ZeroWord;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader (ADDR_W=2): table of directed images, hand
// sequences for reload/async reset, then random images vs a byte-list model.
module tb_inst_rom_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 2**AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_last, reload, rom_ce;
    logic [7:0]  ld_byte;
    logic [31:0] rom_addr;
    logic        ld_ready, cpu_rst, load_done, load_err;
    logic [31:0] rom_data;
    logic [AW:0] load_words;

    int nvec = 0;
    int nmis = 0;

    inst_rom_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_ready(ld_ready), .reload(reload),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err),
        .load_words(load_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               n;
        bit               last;
        logic [16:0][7:0] b;
        bit               exp_run;
        bit               exp_err;
        int               exp_words;
        int               nchk;
        logic [3:0][31:0] w;
    } vec_t;

    vec_t        tv [6];
    logic [31:0] mem_m [DEPTH];
    bit          mval  [DEPTH];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit last, input bit gaps);
        int g;
        g = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            ld_valid = 1'b0;
            ld_last  = ($urandom_range(0, 1) == 1);
            ld_byte  = 8'($urandom);
            @(posedge clk); #1;
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        for (int t = 0; t < 50 && !ld_ready; t++) begin
            @(posedge clk); #1;
        end
        chk("ld_ready_wait", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic read_word(input int idx, output logic [31:0] d);
        logic [31:0] a;
        a        = $urandom;
        a[3:2]   = 2'(idx);
        rom_ce   = 1'b1;
        rom_addr = a;
        #1;
        d = rom_data;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload_done", 32'(load_done), 32'd0);
        chk("reload_err", 32'(load_err), 32'd0);
        chk("reload_ready", 32'(ld_ready), 32'd1);
        chk("reload_words", 32'(load_words), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  rb [17];
        int          n, nw;
        bit          err;

        rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h0;
        reload = 1'b0; rom_ce = 1'b1; rom_addr = 32'h0;

        for (int i = 0; i < 6; i++) begin
            tv[i].n = 0; tv[i].last = 1'b1; tv[i].b = '0;
            tv[i].exp_run = 1'b1; tv[i].exp_err = 1'b0;
            tv[i].exp_words = 0; tv[i].nchk = 0; tv[i].w = '0;
        end
        tv[0].n = 8;
        tv[0].b[7:0] = {8'h20, 8'h00, 8'h02, 8'h34, 8'h00, 8'h11, 8'h01, 8'h34};
        tv[0].exp_words = 2; tv[0].nchk = 2;
        tv[0].w[1:0] = {32'h34020020, 32'h34011100};
        tv[1].n = 5;
        tv[1].b[4:0] = {8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        tv[1].exp_words = 2; tv[1].nchk = 2;
        tv[1].w[1:0] = {32'hEE000000, 32'hAABBCCDD};
        tv[2].n = 17; tv[2].last = 1'b0;
        for (int k = 0; k < 17; k++) tv[2].b[k] = 8'(8'h10 + k);
        tv[2].exp_run = 1'b0; tv[2].exp_err = 1'b1; tv[2].exp_words = 4;
        tv[3].n = 16;
        for (int k = 0; k < 16; k++) tv[3].b[k] = 8'(8'h40 + k);
        tv[3].exp_words = 4; tv[3].nchk = 4;
        tv[3].w = {32'h4C4D4E4F, 32'h48494A4B, 32'h44454647, 32'h40414243};
        tv[4].n = 4;
        tv[4].b[3:0] = {8'h44, 8'h33, 8'h22, 8'h11};
        tv[4].exp_words = 1; tv[4].nchk = 4;
        tv[4].w = {32'h4C4D4E4F, 32'h48494A4B, 32'h44454647, 32'h11223344};
        tv[5].n = 1;
        tv[5].b[0] = 8'hEE;
        tv[5].exp_words = 1; tv[5].nchk = 2;
        tv[5].w[1:0] = {32'h44454647, 32'hEE000000};

        // Reset state
        #12;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_words", 32'(load_words), 32'd0);
        chk("rst_rom_data", rom_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready_pre_edge", 32'(ld_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_ready_post_edge", 32'(ld_ready), 32'd1);

        // Directed images
        for (int i = 0; i < 6; i++) begin
            if (i > 0) do_reload();
            for (int k = 0; k < tv[i].n; k++)
                push(tv[i].b[k], tv[i].last && (k == tv[i].n - 1), i == 1);
            chk($sformatf("tv%0d_done", i), 32'(load_done), 32'(tv[i].exp_run));
            chk($sformatf("tv%0d_err", i), 32'(load_err), 32'(tv[i].exp_err));
            chk($sformatf("tv%0d_cpu_rst", i), 32'(cpu_rst), 32'(!tv[i].exp_run));
            chk($sformatf("tv%0d_ready", i), 32'(ld_ready), 32'd0);
            chk($sformatf("tv%0d_words", i), 32'(load_words), 32'(tv[i].exp_words));
            for (int j = 0; j < tv[i].nchk; j++) begin
                read_word(j, d);
                chk($sformatf("tv%0d_mem%0d", i, j), d, tv[i].w[j]);
            end
            rom_ce = tv[i].exp_err;
            #1;
            chk($sformatf("tv%0d_rom_gated", i), rom_data, 32'h0);
        end

        // Reload in LOAD drops the partial word and a coincident byte
        do_reload();
        push(8'hAB, 1'b0, 1'b0);
        push(8'hCD, 1'b0, 1'b0);
        reload = 1'b1; ld_valid = 1'b1; ld_byte = 8'h99; ld_last = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        chk("rl_load_done", 32'(load_done), 32'd0);
        chk("rl_load_ready", 32'(ld_ready), 32'd1);
        chk("rl_load_words", 32'(load_words), 32'd0);
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        push(8'h04, 1'b1, 1'b0);
        chk("rl_load_words_after", 32'(load_words), 32'd1);
        read_word(0, d);
        chk("rl_load_mem0", d, 32'h01020304);

        // Async reset mid-load
        do_reload();
        for (int k = 0; k < 7; k++) push(8'(8'hC0 + k), 1'b0, 1'b0);
        chk("ar_words_pre", 32'(load_words), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("ar_ready", 32'(ld_ready), 32'd0);
        chk("ar_words", 32'(load_words), 32'd0);
        chk("ar_done", 32'(load_done), 32'd0);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        push(8'h5A, 1'b0, 1'b0);
        push(8'h6B, 1'b0, 1'b0);
        push(8'h7C, 1'b0, 1'b0);
        push(8'h8D, 1'b1, 1'b0);
        chk("ar_reload_done", 32'(load_done), 32'd1);
        chk("ar_reload_words", 32'(load_words), 32'd1);
        read_word(0, d);
        chk("ar_mem0", d, 32'h5A6B7C8D);

        // Random images against the byte-list model
        for (int w = 0; w < DEPTH; w++) mval[w] = 1'b0;
        for (int it = 0; it < 25; it++) begin
            err = ($urandom_range(0, 4) == 0);
            n   = err ? 17 : int'($urandom_range(1, 16));
            for (int k = 0; k < n; k++) rb[k] = 8'($urandom);
            do_reload();
            for (int k = 0; k < n; k++) push(rb[k], !err && (k == n - 1), 1'b1);
            nw = err ? DEPTH : (n + 3) / 4;
            for (int w = 0; w < nw; w++) begin
                mem_m[w] = 32'h0;
                for (int l = 0; l < 4; l++)
                    if (4*w + l < n && 4*w + l < 4*DEPTH)
                        mem_m[w] |= 32'(rb[4*w + l]) << (24 - 8*l);
                mval[w] = 1'b1;
            end
            chk($sformatf("rnd%0d_done", it), 32'(load_done), 32'(!err));
            chk($sformatf("rnd%0d_err", it), 32'(load_err), 32'(err));
            chk($sformatf("rnd%0d_words", it), 32'(load_words), 32'(nw));
            if (!err) begin
                for (int w = 0; w < DEPTH; w++)
                    if (mval[w]) begin
                        read_word(w, d);
                        chk($sformatf("rnd%0d_mem%0d", it, w), d, mem_m[w]);
                    end
            end else begin
                read_word(0, d);
                chk($sformatf("rnd%0d_err_rom", it), d, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction memory with a byte-serial boot loader. It sits directly upstream of the openmips core and drives the core's `rom_data_i` from the core's `rom_addr_o` / `rom_ce_o`. After reset it accepts a program image as a stream of bytes, packs the bytes big-endian into 32-bit words and writes them from word 0 upward. While loading it holds the core in reset; once the last byte is written it releases the core.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width. Depth is `DEPTH = 2**ADDR_W` words.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  a load byte is presented.
- `ld_byte`  in  8  load byte. The first byte of each word goes to bits 31:24.
- `ld_last`  in  1  marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`  out  1  loader accepts a byte. A byte transfers when `ld_valid && ld_ready` at a rising edge.
- `reload`  in  1  single-cycle request to restart loading.
- `rom_ce`  in  1  core fetch enable.
- `rom_addr`  in  32  core byte address. Word index is `rom_addr[ADDR_W+1:2]`; the other bits are ignored.
- `rom_data`  out  32  instruction word; combinational read.
- `cpu_rst`  out  1  active-high reset to the core.
- `load_done`  out  1  image loaded; core running.
- `load_err`  out  1  image overflowed the memory.
- `load_words`  out  `ADDR_W+1`  number of words written by the current or last load.

## Operation
- States: LOAD, RUN, ERR. Reset state is LOAD.
- Registers: byte counter `bcnt` (2 bits), word counter `wcnt` (`ADDR_W+1` bits), 24-bit partial-word shift register.
- **LOAD, normal bytes**
  - `ld_ready=1`.
  - Each accepted byte fills the next byte lane and increments `bcnt`.
  - On the 4th byte (`bcnt==3`), write `{partial, ld_byte}` to `mem[wcnt]`, increment `wcnt`, clear `bcnt`.
- **LOAD, last byte** (accepted with `ld_last=1`):
  - Write the partial word with the unfilled low lanes set to 0x00.
  - Increment `wcnt` and go to RUN.
  - If `ld_last` arrives with `bcnt==0`, the byte starts a new word padded 0x000000 (e.g. `0xEE000000`).
- **Overflow**: a byte accepted while `wcnt==DEPTH` is not written; go to ERR. Filling exactly `DEPTH` words with `ld_last` on the final byte is legal and goes to RUN.
- **RUN**: `ld_ready=0`; `load_done=1`; `cpu_rst=0`.
- **ERR**: `ld_ready=0`; `load_err=1`; `cpu_rst=1`.
- **`reload`** in RUN or ERR: next state LOAD; clear `bcnt` and `wcnt`; clear `load_done` / `load_err`. In LOAD, `reload` restarts at word 0 and discards any partial word. A byte accepted in the same cycle as `reload` is discarded.
- **Outputs by state**: `cpu_rst = (state != RUN)`. `rom_data = (rom_ce && state==RUN) ? mem[index] : 32'h0`.
- **Memory**: contents are not cleared by reset or `reload`. Words beyond `load_words` keep stale data.

## Timing
- While `rst` is low, immediately (asynchronously):
  - `cpu_rst=1`, `ld_ready=0`, `load_done=0`, `load_err=0`, `load_words=0`, `rom_data=0`.
  - State LOAD, `bcnt=0`.
- `ld_ready` becomes 1 on the first clock after `rst` is released.
- Sustained throughput: one byte per clock; `ld_valid` gaps are allowed.
- Memory write latency: a word is visible in `mem` after the edge that accepts its 4th (or last) byte.
- Release latency: the edge that accepts the last byte sets `load_done=1` and `cpu_rst=0` in the following cycle.
- Read latency: zero cycles.
- `reload` is sampled at the edge; `cpu_rst=1` and `load_done=0` in the next cycle.
- Asynchronous reset mid-load abandons the partial word; the next load starts at word 0, lane 0.

## Structure
- Add to `defines.v`:
  - `InstBus`, `InstAddrBus` (already present).
  - Loader state encodings `LdLoad`, `LdRun`, `LdErr`.
  - `ZeroWord`.
- Sub-module `inst_rom_array`: `DEPTH` × 32 storage with one synchronous write port and one asynchronous read port. Everything else lives in the top loader.

## Test plan
1. **Reset**: hold `rst=0` → `cpu_rst=1`, `ld_ready=0`, `load_done=0`, `load_err=0`, `rom_data=0`; release → `ld_ready=1` one edge later.
2. **Two-word load**: bytes 34 01 11 00 34 02 00 20, `ld_last` on the 8th → next cycle `load_done=1`, `cpu_rst=0`, `load_words=2`; `rom_ce=1`, `rom_addr=0x4` → `rom_data=0x34020020`; `rom_addr=0x0` → `0x34011100`; `rom_ce=0` → `0x0`.
3. **Partial last word with gaps**: bytes AA BB CC DD EE (`ld_last` on EE), `ld_valid` toggled randomly → `mem[0]=0xAABBCCDD`, `mem[1]=0xEE000000`, `load_words=2`.
4. **Overflow**, `ADDR_W=2`: 16 bytes without `ld_last` then a 17th byte → `load_err=1`, `ld_ready=0`, `cpu_rst=1`, `mem` unchanged by the 17th byte. Separately, 16 bytes with `ld_last` on the 16th → RUN, `load_words=4`.
5. **Reload in RUN**: pulse `reload` → next cycle `cpu_rst=1`, `load_done=0`, `ld_ready=1`; load 11 22 33 44 with `ld_last` → `mem[0]=0x11223344`, `load_words=1`.
6. **Async reset mid-load**: assert `rst` after 3 bytes → outputs reset without a clock edge; reload 4 bytes → `mem[0]` equals the new word, no lane shift.
